// File: rtl/cblock_cfg_loader.sv
// Serial-to-parallel config loader for a row of latch-based Cblock tiles.
// A frame is assembled MSB first, then written through setup/pulse/hold windows.
module cblock_cfg_loader #(
  parameter  int NUM_TILES = 4,
  parameter  int FRAME_W   = 18,
  parameter  int SETUP_CYC = 1,
  parameter  int WR_CYC    = 2,
  parameter  int HOLD_CYC  = 1,
  localparam int TIDX_W    = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 cfg_valid,
  input  logic                 cfg_data,
  output logic                 cfg_ready,
  output logic [FRAME_W-1:0]   bits_o,
  output logic [NUM_TILES-1:0] wr_en_o,
  output logic [TIDX_W-1:0]    tile_idx,
  output logic                 busy,
  output logic                 done
);

  localparam int CNT_MAX0 = (FRAME_W > SETUP_CYC) ? FRAME_W : SETUP_CYC;
  localparam int CNT_MAX1 = (WR_CYC > HOLD_CYC) ? WR_CYC : HOLD_CYC;
  localparam int CNT_MAX  = (CNT_MAX0 > CNT_MAX1) ? CNT_MAX0 : CNT_MAX1;
  localparam int CNT_W    = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {IDLE, SHIFT, SETUP, WRITE, HOLD, DONE} state_t;

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [TIDX_W-1:0]  tile_n;
  logic [FRAME_W-1:0] sreg, sreg_n;
  logic               load;

  assign cfg_ready = (state == SHIFT);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    tile_n  = tile_idx;
    sreg_n  = sreg;
    load    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_n = SHIFT;
          cnt_n   = '0;
          tile_n  = '0;
        end
      end
      SHIFT: begin
        if (cfg_valid) begin
          sreg_n = {sreg[FRAME_W-2:0], cfg_data};
          if (cnt == CNT_W'(FRAME_W - 1)) begin
            // bits_o takes the frame including the bit arriving this edge
            load    = 1'b1;
            state_n = SETUP;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
      end
      SETUP: begin
        if (cnt == CNT_W'(SETUP_CYC - 1)) begin
          state_n = WRITE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      WRITE: begin
        if (cnt == CNT_W'(WR_CYC - 1)) begin
          state_n = HOLD;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      HOLD: begin
        if (cnt == CNT_W'(HOLD_CYC - 1)) begin
          cnt_n = '0;
          if (tile_idx == TIDX_W'(NUM_TILES - 1)) begin
            state_n = DONE;
          end else begin
            state_n = SHIFT;
            tile_n  = tile_idx + TIDX_W'(1);
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Outputs are registered from next-state so wr_en_o/busy/done line up with the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      tile_idx <= '0;
      sreg     <= '0;
      bits_o   <= '0;
      wr_en_o  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      tile_idx <= tile_n;
      sreg     <= sreg_n;
      if (load) bits_o <= sreg_n;
      wr_en_o  <= (state_n == WRITE) ? (NUM_TILES'(1) << tile_n) : '0;
      busy     <= (state_n != IDLE);
      done     <= (state_n == DONE);
    end
  end

endmodule

// File: tb/tb_cblock_cfg_loader.sv
// Directed bench for cblock_cfg_loader with two tiles and default timing windows.
module tb_cblock_cfg_loader;

  logic        clk = 1'b0;
  logic        rst, start, cfg_valid, cfg_data;
  logic        cfg_ready, busy, done;
  logic [17:0] bits_o;
  logic [1:0]  wr_en_o;
  logic [0:0]  tile_idx;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cblock_cfg_loader #(.NUM_TILES(2), .FRAME_W(18), .SETUP_CYC(1), .WR_CYC(2), .HOLD_CYC(1)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_valid(cfg_valid), .cfg_data(cfg_data),
    .cfg_ready(cfg_ready), .bits_o(bits_o), .wr_en_o(wr_en_o), .tile_idx(tile_idx),
    .busy(busy), .done(done)
  );

  task automatic apply_reset();
    rst = 1'b1; start = 1'b0; cfg_valid = 1'b0; cfg_data = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [23:0] outs;
    rst = 1'b1; start = 1'b0; cfg_valid = 1'b0; cfg_data = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (c == 1) rst = 1'b0;
      outs = {bits_o, wr_en_o, tile_idx, busy, done, cfg_ready};
      checks++;
      if (outs !== 24'h0) begin
        errors++;
        $display("FAIL reset_idle cycle %0d outputs=%h expected=000000", c, outs);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [17:0] f0, f1, exp_bits;
    logic [1:0]  exp_wr;
    logic        exp_rdy, exp_done, exp_busy;
    f0 = 18'h2A5C3; f1 = 18'h15A3C;
    apply_reset();
    @(posedge clk); #1;
    start = 1'b1; cfg_valid = 1'b1; cfg_data = 1'b0;
    for (int c = 1; c <= 47; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      exp_rdy  = (c >= 1 && c <= 18) || (c >= 23 && c <= 40);
      exp_bits = (c >= 41) ? f1 : (c >= 19) ? f0 : 18'h0;
      exp_wr   = (c == 20 || c == 21) ? 2'b01 : (c == 42 || c == 43) ? 2'b10 : 2'b00;
      exp_done = (c == 45);
      exp_busy = (c <= 45);
      if (c <= 18) cfg_data = f0[18-c];
      else if (c >= 23 && c <= 40) cfg_data = f1[40-c];
      else cfg_data = 1'($urandom_range(0, 1));
      checks++;
      if (cfg_ready !== exp_rdy) begin
        errors++; $display("FAIL b2b_ready cycle %0d got=%b expected=%b", c, cfg_ready, exp_rdy);
      end
      checks++;
      if (bits_o !== exp_bits) begin
        errors++; $display("FAIL b2b_bits cycle %0d got=%h expected=%h", c, bits_o, exp_bits);
      end
      checks++;
      if (wr_en_o !== exp_wr) begin
        errors++; $display("FAIL b2b_wr_en cycle %0d got=%b expected=%b", c, wr_en_o, exp_wr);
      end
      checks++;
      if (done !== exp_done) begin
        errors++; $display("FAIL b2b_done cycle %0d got=%b expected=%b", c, done, exp_done);
      end
      checks++;
      if (busy !== exp_busy) begin
        errors++; $display("FAIL b2b_busy cycle %0d got=%b expected=%b", c, busy, exp_busy);
      end
    end
    cfg_valid = 1'b0;
  endtask

  // mode 0: valid whenever ready, 1: valid on every other ready cycle, 2: random valid.
  // Non-ready cycles present valid=1 with random data to exercise gating.
  task automatic run_session(input logic [17:0] f0, input logic [17:0] f1, input int mode,
                             input int spulse, output int shift0);
    logic [17:0] fr [2];
    logic [17:0] prev_bits;
    logic        prev_ready, v, fin;
    int          tile_rx, bitp, rc, cyc, dones, t;
    int          wr_cnt [2];
    fr[0] = f0; fr[1] = f1;
    tile_rx = 0; bitp = 0; rc = 0; cyc = 0; dones = 0; shift0 = 0;
    wr_cnt[0] = 0; wr_cnt[1] = 0; fin = 1'b0;
    prev_bits = bits_o; prev_ready = 1'b0;
    start = 1'b1; cfg_valid = 1'b0;
    while (!fin) begin
      @(posedge clk); #1;
      cyc++;
      start = (cyc == spulse);
      checks++;
      if (bits_o !== prev_bits && !prev_ready) begin
        errors++; $display("FAIL bits_stable cycle %0d got=%h previous=%h", cyc, bits_o, prev_bits);
      end
      if (wr_en_o !== 2'b00) begin
        t = wr_en_o[1] ? 1 : 0;
        wr_cnt[t]++;
        checks++;
        if (!$onehot(wr_en_o) || cfg_ready !== 1'b0 || tile_idx !== 1'(t)) begin
          errors++;
          $display("FAIL wr_onehot cycle %0d wr_en=%b ready=%b tile=%0d expected onehot ready=0 tile=%0d",
                   cyc, wr_en_o, cfg_ready, tile_idx, t);
        end
        checks++;
        if (bits_o !== fr[t]) begin
          errors++; $display("FAIL wr_frame tile %0d got=%h expected=%h", t, bits_o, fr[t]);
        end
      end
      if (cfg_ready === 1'b1 && tile_rx == 0) shift0++;
      prev_bits = bits_o; prev_ready = cfg_ready;
      if (done === 1'b1) begin
        dones++;
        fin = 1'b1;
        cfg_valid = 1'b0;
      end else if (cyc >= 2000) begin
        checks++; errors++;
        $display("FAIL session_timeout cycles=%0d done_seen=0 expected=1", cyc);
        fin = 1'b1;
        cfg_valid = 1'b0;
      end else if (cfg_ready === 1'b1 && tile_rx < 2) begin
        v = (mode == 0) ? 1'b1 : (mode == 1) ? 1'(rc % 2) : 1'($urandom_range(0, 1));
        rc++;
        cfg_valid = v;
        cfg_data  = 1'($urandom_range(0, 1));
        if (v) begin
          cfg_data = fr[tile_rx][17-bitp];
          bitp++;
          if (bitp == 18) begin
            bitp = 0; rc = 0; tile_rx++;
          end
        end
      end else begin
        cfg_valid = 1'b1;
        cfg_data  = 1'($urandom_range(0, 1));
      end
    end
    checks++;
    if (wr_cnt[0] != 2 || wr_cnt[1] != 2) begin
      errors++; $display("FAIL wr_pulse_len tile0=%0d tile1=%0d expected=2 2", wr_cnt[0], wr_cnt[1]);
    end
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || bits_o !== f1) begin
      errors++;
      $display("FAIL session_end busy=%b done=%b bits=%h expected busy=0 done=0 bits=%h", busy, done, bits_o, f1);
    end
  endtask

  task automatic test_stall();
    int s;
    run_session(18'h3C96A, 18'h0F0F1, 1, 0, s);
    checks++;
    if (s != 36) begin
      errors++; $display("FAIL stall_shift_cycles got=%0d expected=36", s);
    end
  endtask

  task automatic test_gating();
    int s;
    run_session(18'h00001, 18'h20000, 0, 0, s);
    checks++;
    if (s != 18) begin
      errors++; $display("FAIL gating_shift_cycles got=%0d expected=18", s);
    end
  endtask

  task automatic test_ignored_start();
    int s;
    run_session(18'h1B2D4, 18'h2E817, 0, 7, s);
  endtask

  task automatic test_reset_mid_write();
    int c;
    apply_reset();
    start = 1'b1; cfg_valid = 1'b1; cfg_data = 1'b1;
    c = 0;
    do begin
      @(posedge clk); #1;
      start = 1'b0; c++;
    end while (wr_en_o === 2'b00 && c < 100);
    checks++;
    if (wr_en_o !== 2'b01) begin
      errors++; $display("FAIL mid_write_reach wr_en=%b expected=01", wr_en_o);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; cfg_valid = 1'b0;
    checks++;
    if (wr_en_o !== 2'b00 || busy !== 1'b0 || cfg_ready !== 1'b0 || tile_idx !== 1'b0) begin
      errors++;
      $display("FAIL mid_write_reset wr_en=%b busy=%b ready=%b tile=%0d expected all 0",
               wr_en_o, busy, cfg_ready, tile_idx);
    end
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || cfg_ready !== 1'b0) begin
      errors++; $display("FAIL mid_write_idle busy=%b ready=%b expected=0 0", busy, cfg_ready);
    end
    run_session(18'h2AAAA, 18'h15555, 0, 0, c);
  endtask

  task automatic test_random();
    int s;
    for (int i = 0; i < 50; i++)
      run_session(18'($urandom), 18'($urandom), 2, int'($urandom_range(0, 10)), s);
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_stall();
    test_gating();
    test_ignored_start();
    test_reset_mid_write();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cblock_cfg_loader.md
Name: cblock_cfg_loader

Overview:
Configuration sequencer for a column/row of Cblock-style tiles whose config storage is high-enable latches sharing one parallel config bus. Accepts a serial bitstream over a valid/ready handshake and assembles one FRAME_W-bit frame per tile. Writes each frame into its tile with a one-hot wr_en pulse, keeping the bus stable through setup, pulse and hold windows. Sits between the top-level bitstream port and the tile array.

Parameters:
NUM_TILES, 4, number of tiles loaded per session (>=1)
FRAME_W, 18, config bits per tile (6 dots x 3 bits)
SETUP_CYC, 1, cycles bits_o is stable before wr_en rises (>=1)
WR_CYC, 2, cycles wr_en is held high (>=1)
HOLD_CYC, 1, cycles bits_o is stable after wr_en falls (>=1)

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous active-high reset
start  input  1  begin a load session; sampled in IDLE only
cfg_valid  input  1  serial bit valid
cfg_data  input  1  serial config bit, frame MSB first
cfg_ready  output  1  loader accepts a bit this cycle
bits_o  output  FRAME_W  shared config bus to all tiles
wr_en_o  output  NUM_TILES  one-hot latch enables, bit i = tile i
tile_idx  output  clog2(NUM_TILES) (min 1)  tile currently being loaded
busy  output  1  session in progress
done  output  1  one-cycle pulse at end of session

Behaviour:
- One clock; reset is synchronous and active-high (clk, rst). Everything is registered; no combinational path from inputs to outputs except cfg_ready, which decodes only from state.
- Reset values: state IDLE, bits_o=0, wr_en_o=0, tile_idx=0, bit counter=0, busy=0, done=0, cfg_ready=0.
- States: IDLE, SHIFT, SETUP, WRITE, HOLD, DONE.
- IDLE: when start=1, go to SHIFT and clear tile_idx and the bit counter. Otherwise stay.
- SHIFT: cfg_ready=1. A bit transfers when cfg_valid && cfg_ready. The shift register shifts left, so the first bit received ends in bit FRAME_W-1. If cfg_valid=0, hold the counter and shift register.
- On the FRAME_W-th accepted bit, load bits_o on that edge with the completed frame, including the current bit, and go to SETUP.
- SETUP: stays SETUP_CYC cycles with wr_en_o=0, then goes to WRITE.
- WRITE: stays WR_CYC cycles with wr_en_o[tile_idx]=1 and all other bits 0, then goes to HOLD.
- HOLD: stays HOLD_CYC cycles with wr_en_o=0.
- On leaving HOLD: if tile_idx==NUM_TILES-1, go to DONE. Otherwise increment tile_idx, clear the bit counter and go to SHIFT.
- DONE: done=1 for exactly one cycle, then IDLE.
- bits_o changes only on the frame-complete edge. It never changes while any wr_en_o bit is high, or in the SETUP/HOLD windows. It retains the last frame after the session.
- busy=1 in every state except IDLE.
- cfg_ready=0 in SETUP/WRITE/HOLD/DONE/IDLE. Bits presented then are not consumed.
- start outside IDLE is ignored, with no restart and no error.
- Reset mid-session: on the reset edge wr_en_o drops to 0 and the FSM returns to IDLE. Tiles keep whatever they had latched. A partially shifted frame is discarded.
- Only one wr_en_o bit may be high in any cycle. wr_en_o is glitch-free because it comes straight from a register.
- Counters are sized for max(FRAME_W, SETUP_CYC, WR_CYC, HOLD_CYC) and must not wrap within a state.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then start=0 for 10 cycles -> all outputs 0 throughout.
- Full back-to-back load (NUM_TILES=2, defaults otherwise):
  - Stimulus: start at cycle 0, cfg_valid=1 continuously. Tile0 frame 18'h2A5C3, tile1 frame 18'h15A3C.
  - Required: SHIFT cycles 1-18; bits_o=18'h2A5C3 from cycle 19.
  - Required: wr_en_o=2'b01 in cycles 20-21.
  - Required: bits_o=18'h15A3C from cycle 41, wr_en_o=2'b10 in cycles 42-43.
  - Required: done=1 only in cycle 45, busy=1 in cycles 1-45.
- Valid stalls: deassert cfg_valid every other cycle -> frame takes 36 cycles and the assembled bits_o equals the sent frame exactly. A bit counter that advances while cfg_valid=0 is a failure.
- Handshake gating: hold cfg_valid=1 with changing cfg_data during SETUP/WRITE/HOLD -> cfg_ready=0 and the next frame is unaffected.
- Reset mid-WRITE: assert rst in the first WRITE cycle -> wr_en_o=0 and state IDLE after that edge. A new start then performs a clean full load.
- Ignored start plus invariants: pulse start during SHIFT -> no restart. The assertion "wr_en_o onehot0" and "bits_o stable whenever |wr_en_o or in SETUP/HOLD" hold over a 50-session random run.
